port_rx: RTL and testbench

//  Serial-to-parallel input front end for the CPU. Receives 8N1 async serial bytes on one pin.

---
 rtl/port_rx_pkg.sv | 14 +
 rtl/port_rx_sync.sv | 16 +
 rtl/port_rx.sv | 127 ++++++++++++
 tb/tb_port_rx.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/port_rx_pkg.sv
// Shared definitions for the serial port blocks: FSM state encodings and defaults.
// Kept in a package so a future port_tx can import the same encodings.
package port_rx_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int DEF_TIMEOUT_BITS = 20;
endpackage

// File: rtl/port_rx_sync.sv
// Two-flop synchronizer for the async rx pin; resets to the idle (high) level.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s
);
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx};
    end

    assign rx_s = sync_q[1];
endmodule

// File: rtl/port_rx.sv
// 8N1 serial receiver that pairs bytes (low first) into 16-bit words for the CPU in_port.
// A lone low byte is dropped after TIMEOUT_BITS idle bit-times.
module port_rx
    import port_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] in_port,
    output logic        word_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int TMO_N = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW    = $clog2(TMO_N);

    rx_state_t   state, state_n;
    logic        rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]  bidx;
    logic [TW-1:0] tmo;
    logic [7:0]  shreg;
    logic [7:0]  lo;
    logic        have_lo;
    logic        bit_end;
    logic        half_end;

    rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s)
    );

    assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
    assign half_end = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (!rx_s) state_n = S_START;
            S_START: if (half_end) state_n = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (bit_end && bidx == 3'd7) state_n = S_STOP;
            S_STOP:  if (bit_end) state_n = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            bidx       <= '0;
            tmo        <= '0;
            shreg      <= '0;
            lo         <= '0;
            have_lo    <= 1'b0;
            in_port    <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    // A start edge outranks a timeout landing on the same cycle.
                    if (!rx_s) begin
                        tmo <= '0;
                    end else if (have_lo) begin
                        if (tmo == TW'(TMO_N - 1)) begin
                            have_lo <= 1'b0;
                            tmo     <= '0;
                        end else begin
                            tmo <= tmo + TW'(1);
                        end
                    end
                end
                S_START: begin
                    bidx <= '0;
                    cnt  <= half_end ? '0 : cnt + CW'(1);
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        bidx  <= bidx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (rx_s) begin
                            if (!have_lo) begin
                                lo      <= shreg;
                                have_lo <= 1'b1;
                                tmo     <= '0;
                            end else begin
                                in_port    <= {shreg, lo};
                                word_valid <= 1'b1;
                                have_lo    <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            have_lo   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_port_rx.sv
// Directed bench for port_rx with CLKS_PER_BIT=8, TIMEOUT_BITS=4.
module tb_port_rx;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] in_port;
    logic        word_valid;
    logic        frame_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int wv_cyc   = 0;
    int wv_long  = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int busy_cyc = 0;
    logic        wv_q = 1'b0;
    logic [15:0] last_word = 16'h0;

    port_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .in_port    (in_port),
        .word_valid (word_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid) begin
                wv_cyc    = wv_cyc + 1;
                last_word = in_port;
                if (wv_q) wv_long = wv_long + 1;
            end
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (frame_err && word_valid) both_cnt = both_cnt + 1;
            if (busy) busy_cyc = busy_cyc + 1;
            wv_q = word_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(b[i], CPB);
        send_bit(stop, CPB);
        rx = 1'b1;
    endtask

    int b0;
    logic [7:0] partial;

    initial begin
        // 1: reset
        rst = 1'b1; rx = 1'b1;
        idle(2);
        check("rst_in_port", 32'(in_port), 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle(4);

        // 2: basic word
        send_byte(8'h34, 1'b1);
        idle(2);
        check("no_wv_after_lo", 32'(wv_cyc), 32'd0);
        check("in_port_held_lo", 32'(in_port), 32'h0);
        send_byte(8'h12, 1'b1);
        idle(4);
        check("word_1234", 32'(in_port), 32'h1234);
        check("wv_one_pulse", 32'(wv_cyc), 32'd1);
        check("wv_pulse_word", 32'(last_word), 32'h1234);
        check("wv_single_cycle", 32'(wv_long), 32'd0);

        // 3: start glitch
        b0 = busy_cyc;
        send_bit(1'b0, 2);
        rx = 1'b1;
        idle(12);
        check("glitch_busy_cycles", 32'(busy_cyc - b0), 32'd4);
        check("glitch_busy_low", 32'(busy), 32'h0);
        check("glitch_in_port", 32'(in_port), 32'h1234);
        check("glitch_no_wv", 32'(wv_cyc), 32'd1);
        check("glitch_no_fe", 32'(fe_cnt), 32'd0);

        // 4: framing error then break, then a clean word
        send_byte(8'h99, 1'b1);
        send_byte(8'h77, 1'b0);
        rx = 1'b0;
        idle(10);
        check("fe_pulse", 32'(fe_cnt), 32'd1);
        check("break_busy", 32'(busy), 32'h1);
        check("fe_in_port", 32'(in_port), 32'h1234);
        check("fe_no_wv", 32'(wv_cyc), 32'd1);
        rx = 1'b1;
        idle(5);
        check("break_release", 32'(busy), 32'h0);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hAB, 1'b1);
        idle(4);
        check("word_abcd", 32'(in_port), 32'hABCD);
        check("wv_after_abcd", 32'(wv_cyc), 32'd2);

        // 5: timeout discards lone low byte
        send_byte(8'h55, 1'b1);
        idle(40);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        idle(4);
        check("word_5678", 32'(in_port), 32'h5678);
        check("wv_after_5678", 32'(wv_cyc), 32'd3);

        // 6: reset during bit 3 of the second byte
        send_byte(8'h44, 1'b1);
        partial = 8'h11;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 3; i++) send_bit(partial[i], CPB);
        send_bit(partial[3], CPB / 2);
        rst = 1'b1; rx = 1'b1;
        idle(1);
        check("midrst_in_port", 32'(in_port), 32'h0);
        check("midrst_word_valid", 32'(word_valid), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        idle(4);
        send_byte(8'h22, 1'b1);
        send_byte(8'h11, 1'b1);
        idle(4);
        check("word_1122", 32'(in_port), 32'h1122);
        check("wv_after_1122", 32'(wv_cyc), 32'd4);
        check("never_wv_and_fe", 32'(both_cnt), 32'd0);
        check("fe_total", 32'(fe_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
